// File: rtl/mem_block_copier.sv
// Block copier: initiator on the async memory port that copies N words from src to dst,
// one word at a time, sampling read data a fixed READ_WAIT cycles after the read strobe.
module mem_block_copier #(
    parameter int unsigned READ_WAIT = 3,
    parameter int unsigned CNT_W     = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] xfer_count,
    output logic [31:0]      mem_addr,
    output logic             mem_read,
    output logic             mem_write,
    output logic [31:0]      mem_write_data,
    input  logic [31:0]      mem_read_data
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRd   = 2'd1;
    localparam logic [1:0] StWr   = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam int unsigned WaitW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(READ_WAIT - 1);

    logic [1:0]       state_q, state_d;
    logic [31:0]      src_ptr_q, src_ptr_d;
    logic [31:0]      dst_ptr_q, dst_ptr_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] xfer_q, xfer_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [31:0]      data_q, data_d;
    logic [31:0]      addr_q;

    always_comb begin
        state_d   = state_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        rem_d     = rem_q;
        xfer_d    = xfer_q;
        wait_d    = wait_q;
        data_d    = data_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    src_ptr_d = {src_addr[31:2], 2'b00};
                    dst_ptr_d = {dst_addr[31:2], 2'b00};
                    rem_d     = word_count;
                    xfer_d    = '0;
                    wait_d    = '0;
                    state_d   = (word_count != '0) ? StRd : StDone;
                end
            end
            StRd: begin
                if (wait_q == WaitLast) begin
                    data_d  = mem_read_data;
                    wait_d  = '0;
                    state_d = StWr;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StWr: begin
                src_ptr_d = src_ptr_q + 32'd4;
                dst_ptr_d = dst_ptr_q + 32'd4;
                rem_d     = rem_q - CNT_W'(1);
                xfer_d    = xfer_q + CNT_W'(1);
                state_d   = (rem_q == CNT_W'(1)) ? StDone : StRd;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Address is a pure mux of registers; addr_q only remembers it for the idle states.
    always_comb begin
        case (state_q)
            StRd:    mem_addr = src_ptr_q;
            StWr:    mem_addr = dst_ptr_q;
            default: mem_addr = addr_q;
        endcase
    end

    assign mem_read       = (state_q == StRd);
    assign mem_write      = (state_q == StWr);
    assign mem_write_data = data_q;
    assign busy           = (state_q != StIdle);
    assign done           = (state_q == StDone);
    assign xfer_count     = xfer_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            rem_q     <= '0;
            xfer_q    <= '0;
            wait_q    <= '0;
            data_q    <= '0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            rem_q     <= rem_d;
            xfer_q    <= xfer_d;
            wait_q    <= wait_d;
            data_q    <= data_d;
            addr_q    <= mem_addr;
        end
    end

endmodule

// File: tb/tb_mem_block_copier.sv
// Directed bench for mem_block_copier: a 1K-word memory model answers the DUT, and each
// scenario checks copied contents, done latency and strobe behaviour.
module tb_mem_block_copier;

    localparam int unsigned CNT_W = 11;

    logic             clk;
    logic             reset;
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [CNT_W-1:0] word_count;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] xfer_count;
    logic [31:0]      mem_addr;
    logic             mem_read;
    logic             mem_write;
    logic [31:0]      mem_write_data;
    logic [31:0]      mem_read_data;

    logic [31:0] mem [0:1023];
    logic        tb_we;
    logic [9:0]  tb_waddr;
    logic [31:0] tb_wdata;

    int n_checks;
    int n_fail;
    int both_hi;

    mem_block_copier #(
        .READ_WAIT(3),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .src_addr      (src_addr),
        .dst_addr      (dst_addr),
        .word_count    (word_count),
        .busy          (busy),
        .done          (done),
        .xfer_count    (xfer_count),
        .mem_addr      (mem_addr),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_write_data(mem_write_data),
        .mem_read_data (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: decodes address[11:2], writes on the rising edge.
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[11:2]] <= mem_write_data;
        else if (tb_we) mem[tb_waddr] <= tb_wdata;
    end
    assign mem_read_data = mem[mem_addr[11:2]];

    always @(negedge clk) if (mem_read && mem_write) both_hi++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic poke(input int unsigned widx, input logic [31:0] val);
        @(negedge clk);
        tb_we    = 1'b1;
        tb_waddr = widx[9:0];
        tb_wdata = val;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // Runs one job; optionally re-pulses start with other inputs at cycle repulse_at.
    task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input int cnt,
                           input int repulse_at, output int lat, output int rd_seen,
                           output int wr_seen, output logic [31:0] first_addr);
        lat = -1; rd_seen = 0; wr_seen = 0; first_addr = 32'hDEAD_BEEF;
        @(negedge clk);
        src_addr   = src;
        dst_addr   = dst;
        word_count = CNT_W'(cnt);
        start      = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start      = 1'b0;
                first_addr = mem_addr;
            end
            if (k == repulse_at) begin
                src_addr   = 32'h0000_0000;
                dst_addr   = 32'h0000_0600;
                word_count = CNT_W'(7);
                start      = 1'b1;
            end else if (k == repulse_at + 1) begin
                start = 1'b0;
            end
            if (mem_read) rd_seen++;
            if (mem_write) wr_seen++;
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    int lat, rd_seen, wr_seen;
    logic [31:0] fa;

    initial begin
        n_checks = 0; n_fail = 0; both_hi = 0;
        reset = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; word_count = '0;
        tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;

        for (int i = 0; i < 1024; i++) poke(i, 32'h0);

        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_rd", 32'(mem_read), 32'd0);
        check_eq("rst_wr", 32'(mem_write), 32'd0);
        check_eq("rst_addr", mem_addr, 32'h0);
        check_eq("rst_wdata", mem_write_data, 32'h0);
        check_eq("rst_xfer", 32'(xfer_count), 32'd0);

        poke(50, 32'd11); poke(51, 32'd22); poke(52, 32'd33); poke(53, 32'd44);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Basic 4-word copy: 4*(3+1)+1 = 17 cycles to done.
        run_job(32'h00C8, 32'h0190, 4, -10, lat, rd_seen, wr_seen, fa);
        check_eq("s1_lat", 32'(lat), 32'd17);
        check_eq("s1_xfer", 32'(xfer_count), 32'd4);
        check_eq("s1_first_addr", fa, 32'h00C8);
        check_eq("s1_rd_cycles", 32'(rd_seen), 32'd12);
        check_eq("s1_wr_cycles", 32'(wr_seen), 32'd4);
        check_eq("s1_w100", mem[100], 32'd11);
        check_eq("s1_w101", mem[101], 32'd22);
        check_eq("s1_w102", mem[102], 32'd33);
        check_eq("s1_w103", mem[103], 32'd44);
        @(negedge clk);
        check_eq("s1_idle_busy", 32'(busy), 32'd0);
        check_eq("s1_done_pulse", 32'(done), 32'd0);

        // Zero-length job.
        run_job(32'h0040, 32'h0080, 0, -10, lat, rd_seen, wr_seen, fa);
        check_eq("s2_lat", 32'(lat), 32'd1);
        check_eq("s2_rd", 32'(rd_seen), 32'd0);
        check_eq("s2_wr", 32'(wr_seen), 32'd0);
        check_eq("s2_xfer", 32'(xfer_count), 32'd0);

        // Unaligned addresses behave as aligned.
        for (int i = 100; i < 104; i++) poke(i, 32'h0);
        run_job(32'h00CB, 32'h0192, 4, -10, lat, rd_seen, wr_seen, fa);
        check_eq("s3_lat", 32'(lat), 32'd17);
        check_eq("s3_first_addr", fa, 32'h00C8);
        check_eq("s3_w100", mem[100], 32'd11);
        check_eq("s3_w103", mem[103], 32'd44);

        // Overlapping ranges replicate word 0.
        poke(0, 32'hA5A5_A5A5); poke(1, 32'h1); poke(2, 32'h2); poke(3, 32'h3);
        run_job(32'h0000, 32'h0004, 3, -10, lat, rd_seen, wr_seen, fa);
        check_eq("s4_lat", 32'(lat), 32'd13);
        check_eq("s4_w1", mem[1], 32'hA5A5_A5A5);
        check_eq("s4_w2", mem[2], 32'hA5A5_A5A5);
        check_eq("s4_w3", mem[3], 32'hA5A5_A5A5);

        // start re-pulsed mid-job is ignored.
        poke(128, 32'hCAFE_0001); poke(129, 32'hCAFE_0002);
        run_job(32'h0200, 32'h0280, 2, 3, lat, rd_seen, wr_seen, fa);
        check_eq("s5_lat", 32'(lat), 32'd9);
        check_eq("s5_xfer", 32'(xfer_count), 32'd2);
        check_eq("s5_w160", mem[160], 32'hCAFE_0001);
        check_eq("s5_w161", mem[161], 32'hCAFE_0002);
        check_eq("s5_w384", mem[384], 32'h0);
        repeat (3) @(negedge clk);
        check_eq("s5_no_restart", 32'(busy), 32'd0);

        // Reset dropped during the 2nd write of a 5-word job.
        for (int i = 0; i < 5; i++) poke(192 + i, 32'h5000_0000 + 32'(i));
        @(negedge clk);
        src_addr = 32'h0300; dst_addr = 32'h0400; word_count = CNT_W'(5); start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check_eq("s6_wr2_active", 32'(mem_write), 32'd1);
        check_eq("s6_wr2_addr", mem_addr, 32'h0404);
        #2 reset = 1'b0;
        #1;
        check_eq("s6_async_wr", 32'(mem_write), 32'd0);
        check_eq("s6_async_busy", 32'(busy), 32'd0);
        check_eq("s6_async_addr", mem_addr, 32'h0);
        check_eq("s6_async_xfer", 32'(xfer_count), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check_eq("s6_no_done", 32'(done), 32'd0);
        end
        reset = 1'b1;
        check_eq("s6_w256", mem[256], 32'h5000_0000);
        check_eq("s6_w257", mem[257], 32'h0);
        check_eq("s6_w258", mem[258], 32'h0);

        run_job(32'h0300, 32'h0500, 2, -10, lat, rd_seen, wr_seen, fa);
        check_eq("s6_after_lat", 32'(lat), 32'd9);
        check_eq("s6_after_w320", mem[320], 32'h5000_0000);
        check_eq("s6_after_w321", mem[321], 32'h5000_0001);

        check_eq("rd_wr_exclusive", 32'(both_hi), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
